// File: rtl/alu_pkg.sv
// Shared opcode constants and scheduler state type for the ALU sharing logic.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_INC  = 3'd2;
  localparam logic [2:0] ALU_DEC  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_NAND = 3'd6;
  localparam logic [2:0] ALU_XOR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } sched_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module alu_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    g
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    any = 1'b0;
    gnt = '0;
    g   = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        any      = 1'b1;
        gnt      = '0;
        gnt[idx] = 1'b1;
        g        = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin front end sharing one external registered ALU between NUM_REQ requesters.
module alu_sched
  import alu_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int OPCODE_WIDTH = 2,
  parameter  int DATA_WIDTH   = 7,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*(OPCODE_WIDTH+1)-1:0] req_opcode,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_op1,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_op2,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [DATA_WIDTH:0]               rsp_result,
  output logic                              rsp_carry,
  output logic                              rsp_zero,
  output logic [OPCODE_WIDTH:0]             alu_opcode,
  output logic [DATA_WIDTH:0]               alu_op1,
  output logic [DATA_WIDTH:0]               alu_op2,
  input  logic [DATA_WIDTH:0]               alu_result,
  input  logic                              alu_carry,
  input  logic                              alu_zero,
  output logic                              busy
);

  localparam int OW = OPCODE_WIDTH + 1;
  localparam int DW = DATA_WIDTH + 1;

  logic [OW-1:0] opc_arr [NUM_REQ];
  logic [DW-1:0] op1_arr [NUM_REQ];
  logic [DW-1:0] op2_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign opc_arr[gi] = req_opcode[gi*OW +: OW];
    assign op1_arr[gi] = req_op1[gi*DW +: DW];
    assign op2_arr[gi] = req_op2[gi*DW +: DW];
  end

  sched_state_t  state_reg;
  logic [ID_W-1:0] rr_ptr_reg;
  logic [ID_W-1:0] id_reg;
  logic [OW-1:0]   alu_opcode_reg;
  logic [DW-1:0]   alu_op1_reg;
  logic [DW-1:0]   alu_op2_reg;
  logic            rsp_valid_reg;
  logic [ID_W-1:0] rsp_id_reg;
  logic [DW-1:0]   rsp_result_reg;
  logic            rsp_carry_reg;
  logic            rsp_zero_reg;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_g;

  alu_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_reg),
    .any    (pick_any),
    .gnt    (pick_gnt),
    .g      (pick_g)
  );

  // Grants are only offered while idle; requests arriving mid-operation wait.
  assign req_ready  = (state_reg == IDLE) ? pick_gnt : '0;
  assign busy       = (state_reg != IDLE);
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_carry  = rsp_carry_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign alu_opcode = alu_opcode_reg;
  assign alu_op1    = alu_op1_reg;
  assign alu_op2    = alu_op2_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      id_reg         <= '0;
      alu_opcode_reg <= '0;
      alu_op1_reg    <= '0;
      alu_op2_reg    <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_carry_reg  <= 1'b0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            alu_opcode_reg <= opc_arr[pick_g];
            alu_op1_reg    <= op1_arr[pick_g];
            alu_op2_reg    <= op2_arr[pick_g];
            id_reg         <= pick_g;
            rr_ptr_reg     <= (pick_g == ID_W'(NUM_REQ - 1)) ? '0 : pick_g + ID_W'(1);
            state_reg      <= EXEC;
          end
        end
        EXEC: state_reg <= CAPT;
        // ALU output reflects the operands registered two edges ago.
        CAPT: begin
          rsp_result_reg <= alu_result;
          rsp_carry_reg  <= alu_carry;
          rsp_zero_reg   <= alu_zero;
          rsp_id_reg     <= id_reg;
          rsp_valid_reg  <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
